// File: rtl/fifo_generator_sync_if.sv
// Handshake/status bundle for fifo_generator_sync. The data_count signal exists only
// when FIFO_GENERATOR_SYNC_DATA_COUNT_EN is defined.
interface fifo_generator_sync_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  almost_full;
  logic                  wr_ack;
  logic                  overflow;
  logic                  empty;
  logic                  almost_empty;
  logic                  valid;
  logic                  underflow;
`ifdef FIFO_GENERATOR_SYNC_DATA_COUNT_EN
  logic [ADDR_WIDTH:0]   data_count;

  modport master (output din, wr_en, rd_en,
                  input  dout, full, almost_full, wr_ack, overflow,
                         empty, almost_empty, valid, underflow, data_count);
  modport slave  (input  din, wr_en, rd_en,
                  output dout, full, almost_full, wr_ack, overflow,
                         empty, almost_empty, valid, underflow, data_count);
`else
  modport master (output din, wr_en, rd_en,
                  input  dout, full, almost_full, wr_ack, overflow,
                         empty, almost_empty, valid, underflow);
  modport slave  (input  din, wr_en, rd_en,
                  output dout, full, almost_full, wr_ack, overflow,
                         empty, almost_empty, valid, underflow);
`endif
endinterface

// File: rtl/fifo_generator_sync.sv
// Single-clock FIFO with standard (FWFT=0) and first-word-fall-through (FWFT=1) read modes.
// Define FIFO_GENERATOR_SYNC_DATA_COUNT_EN to add the data_count port and its occupancy counter.
module fifo_generator_sync #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int FWFT         = 0,
  parameter int AFULL_LEVEL  = 2**ADDR_WIDTH - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  fifo_generator_sync_if.slave bus
);

  localparam int              DEPTH    = 2**ADDR_WIDTH;
  localparam int              CW       = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]   AFULL_C  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0]   AEMPTY_C = CW'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         wr_ptr_q, rd_ptr_q, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]         mem_occ_nxt, total_nxt;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  full_q, almost_full_q, empty_q, almost_empty_q;
  logic                  valid_q, wr_ack_q, overflow_q, underflow_q;
  logic                  oreg_q, oreg_nxt, wr_acc, rd_ok, mem_rd;
`ifdef FIFO_GENERATOR_SYNC_DATA_COUNT_EN
  logic [CW-1:0]         data_count_q;
`endif

  // In FWFT mode valid doubles as the output-register occupancy bit.
  assign oreg_q = (FWFT != 0) && valid_q;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred;
  // combinational logic uses blocking '=' only.
  always_comb begin
    wr_acc = bus.wr_en && !full_q;
    if (FWFT != 0) begin
      rd_ok    = bus.rd_en && oreg_q;
      mem_rd   = (wr_ptr_q != rd_ptr_q) && (!oreg_q || rd_ok);
      oreg_nxt = mem_rd || (oreg_q && !rd_ok);
    end else begin
      rd_ok    = bus.rd_en && !empty_q;
      mem_rd   = rd_ok;
      oreg_nxt = 1'b0;
    end
    wr_ptr_nxt = wr_ptr_q + CW'(wr_acc);
    rd_ptr_nxt = rd_ptr_q + CW'(mem_rd);
`ifdef FIFO_GENERATOR_SYNC_DATA_COUNT_EN
    mem_occ_nxt = data_count_q - CW'(oreg_q) + CW'(wr_acc) - CW'(mem_rd);
`else
    // Pointer MSB makes the difference span 0..DEPTH without ambiguity.
    mem_occ_nxt = wr_ptr_nxt - rd_ptr_nxt;
`endif
    total_nxt = mem_occ_nxt + CW'(oreg_nxt);
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      dout_q         <= '0;
      valid_q        <= 1'b0;
      wr_ack_q       <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
`ifdef FIFO_GENERATOR_SYNC_DATA_COUNT_EN
      data_count_q   <= '0;
`endif
    end else begin
      wr_ptr_q       <= wr_ptr_nxt;
      rd_ptr_q       <= rd_ptr_nxt;
      if (mem_rd) dout_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      valid_q        <= (FWFT != 0) ? oreg_nxt : rd_ok;
      wr_ack_q       <= wr_acc;
      overflow_q     <= bus.wr_en && full_q;
      underflow_q    <= bus.rd_en && !rd_ok;
      // Flags come from next-state occupancy so they are coherent every cycle.
      full_q         <= (mem_occ_nxt == DEPTH_C);
      almost_full_q  <= (mem_occ_nxt >= AFULL_C);
      empty_q        <= (FWFT != 0) ? !oreg_nxt : (mem_occ_nxt == '0);
      almost_empty_q <= (total_nxt <= AEMPTY_C);
`ifdef FIFO_GENERATOR_SYNC_DATA_COUNT_EN
      data_count_q   <= total_nxt;
`endif
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers already discards it.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.din;
  end

  assign bus.dout         = dout_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.wr_ack       = wr_ack_q;
  assign bus.overflow     = overflow_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.valid        = valid_q;
  assign bus.underflow    = underflow_q;
`ifdef FIFO_GENERATOR_SYNC_DATA_COUNT_EN
  assign bus.data_count   = data_count_q;
`endif

endmodule
